// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder: FSM state encoding and
// the word geometry of the 64-bit data memory.
// -----------------------------------------------------------------------------
package dmem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // ready for a new request
        WAIT = 2'd1,   // latency countdown
        RESP = 2'd2    // response presented, waiting for resp_ready
    } state_e;

    localparam int WORD_BYTES = 8;                // bytes per memory word
    localparam int ALIGN_BITS = 3;                // log2(WORD_BYTES)
    localparam int WORD_W     = WORD_BYTES * 8;   // bits per memory word

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH x 64-bit data storage with one synchronous write port and one
// synchronous read port. The whole array and the read register are cleared
// synchronously while reset is high.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset (clears array and read data)
//   wr_en    in   write wr_data into word wr_idx on this edge
//   wr_idx   in   write word index
//   wr_data  in   write data
//   rd_en    in   capture word rd_idx into rd_data on this edge
//   rd_idx   in   read word index
//   rd_data  out  registered read data, held until the next rd_en
// -----------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_data_q;
    logic [WORD_W-1:0] rd_data_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the array must read as zero after reset, so it is cleared word by word; this keeps it out of plain RAM macros.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_idx] <= wr_data;
            end
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory side of the MEM-stage load/store interface. Accepts one LDUR/STUR at
// a time, waits LATENCY cycles, then commits the access to the data array and
// presents the response until the MEM stage takes it.
//
// Parameters:
//   DEPTH     number of 64-bit words (power of two, >= 2)
//   LATENCY   cycles from request accept to resp_valid (>= 1)
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  responder can accept (IDLE)
//   req_write   in   1 = STUR, 0 = LDUR
//   req_addr    in   byte address
//   req_wdata   in   store data
//   resp_valid  out  response present
//   resp_ready  in   MEM stage takes the response
//   resp_rdata  out  load data; 0 for stores and errors
//   resp_error  out  misaligned or out-of-range access
//   busy        out  access outstanding (state != IDLE)
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    // State and request latch.
    state_e            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              write_q,  write_d;
    logic [WORD_W-1:0] addr_q,   addr_d;
    logic [WORD_W-1:0] wdata_q,  wdata_d;

    // Registered outputs.
    logic              req_ready_q,  req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_error_q, resp_error_d;
    logic              busy_q,       busy_d;
    // High while resp_rdata must show the array read register (good load).
    logic              rdata_en_q,   rdata_en_d;

    // Commit-edge view of the access. With LATENCY=1 the commit edge is the
    // accept edge itself, so the request is taken straight from the inputs.
    logic              commit;
    logic              c_write;
    logic [WORD_W-1:0] c_addr;
    logic [WORD_W-1:0] c_wdata;
    logic              c_err;

    logic [WORD_W-1:0] arr_rdata;

    always_comb begin
        c_write = (state_q == IDLE) ? req_write : write_q;
        c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
        c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
        // Upper-bit test is the unsigned addr>>3 >= DEPTH check without wrap.
        c_err   = (c_addr[ALIGN_BITS-1:0] != '0) ||
                  (c_addr[WORD_W-1:ALIGN_BITS+IDX_W] != '0);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_error_d = resp_error_q;
        rdata_en_d   = rdata_en_q;
        commit       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 1) begin
                        commit = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_error_d = 1'b0;
                    rdata_en_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            state_d      = RESP;
            resp_error_d = c_err;
            rdata_en_d   = !c_err && !c_write;
        end

        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            busy_q       <= 1'b0;
            rdata_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            busy_q       <= busy_d;
            rdata_en_q   <= rdata_en_d;
        end
    end

    // Array reset shares the responder reset, so a reset on the commit edge
    // also suppresses the write.
    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (commit && !c_err && c_write),
        .wr_idx  (c_addr[ALIGN_BITS +: IDX_W]),
        .wr_data (c_wdata),
        .rd_en   (commit && !c_err && !c_write),
        .rd_idx  (c_addr[ALIGN_BITS +: IDX_W]),
        .rd_data (arr_rdata)
    );

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign busy       = busy_q;
    // The array read register holds the loaded word through RESP; stores,
    // errors and idle cycles show zero.
    assign resp_rdata = rdata_en_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Two responders share clock and reset: u_dut0 with LATENCY=2 and u_dut1 with
// LATENCY=1. A transaction-level model (memory array plus a countdown to the
// response) predicts every output of both instances each cycle; directed
// sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic clock = 1'b0;
    logic reset;

    logic [1:0]        req_valid, req_ready, req_write;
    logic [1:0]        resp_valid, resp_ready, resp_error, busy;
    logic [1:0][63:0]  req_addr, req_wdata, resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut0 (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_write  (req_write[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .resp_valid (resp_valid[0]),
        .resp_ready (resp_ready[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_error (resp_error[0]),
        .busy       (busy[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_write  (req_write[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .resp_valid (resp_valid[1]),
        .resp_ready (resp_ready[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_error (resp_error[1]),
        .busy       (busy[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [63:0] m_mem [2][DEPTH];
    bit          m_on = 1'b0;
    bit          m_busy [2];
    bit          m_resp [2];
    bit          m_err  [2];
    bit          m_wr   [2];
    int          m_left [2];
    logic [63:0] m_data [2];
    logic [63:0] m_addr [2];
    logic [63:0] m_wdata[2];

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic m_commit(input int i);
        logic [63:0] word;
        bit          bad;
        word = m_addr[i] >> 3;
        bad  = ((m_addr[i] & 64'd7) != 64'd0) || (word >= 64'(DEPTH));
        m_data[i] = 64'd0;
        if (!bad) begin
            if (m_wr[i]) m_mem[i][int'(word)] = m_wdata[i];
            else         m_data[i] = m_mem[i][int'(word)];
        end
        m_err[i]  = bad;
        m_resp[i] = 1'b1;
    endtask

    initial forever begin
        @(posedge clock);
        if (reset) begin
            m_on = 1'b1;
            for (int i = 0; i < 2; i++) begin
                for (int w = 0; w < DEPTH; w++) m_mem[i][w] = 64'd0;
                m_busy[i] = 1'b0;
                m_resp[i] = 1'b0;
                m_err[i]  = 1'b0;
                m_left[i] = 0;
                m_data[i] = 64'd0;
            end
        end else if (m_on) begin
            for (int i = 0; i < 2; i++) begin
                if (m_resp[i]) begin
                    if (resp_ready[i]) begin
                        m_resp[i] = 1'b0;
                        m_busy[i] = 1'b0;
                        m_err[i]  = 1'b0;
                        m_data[i] = 64'd0;
                    end
                end else if (m_busy[i]) begin
                    m_left[i]--;
                    if (m_left[i] == 0) m_commit(i);
                end else if (req_valid[i]) begin
                    m_busy[i]  = 1'b1;
                    m_wr[i]    = req_write[i];
                    m_addr[i]  = req_addr[i];
                    m_wdata[i] = req_wdata[i];
                    m_left[i]  = lat_of(i) - 1;
                    if (m_left[i] == 0) m_commit(i);
                end
            end
        end
    end

    // Every-cycle comparison, half a cycle away from the active edge.
    initial forever begin
        @(negedge clock);
        if (m_on) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d.req_ready", i),  64'(req_ready[i]),  64'(!m_busy[i]));
                check($sformatf("u%0d.busy", i),       64'(busy[i]),       64'(m_busy[i]));
                check($sformatf("u%0d.resp_valid", i), 64'(resp_valid[i]), 64'(m_resp[i]));
                check($sformatf("u%0d.resp_error", i), 64'(resp_error[i]), 64'(m_err[i]));
                check($sformatf("u%0d.resp_rdata", i), resp_rdata[i],      m_data[i]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Called just after a rising edge with instance i idle. hold > 0 keeps
    // resp_ready low for that many cycles and pulses a stray store meanwhile.
    task automatic do_req(input int i, input bit wr, input logic [63:0] addr,
                          input logic [63:0] wdata, input int hold,
                          output logic [63:0] rdata, output bit err, output int lat);
        req_valid[i]  = 1'b1;
        req_write[i]  = wr;
        req_addr[i]   = addr;
        req_wdata[i]  = wdata;
        resp_ready[i] = (hold == 0);
        lat = 0;
        while (lat < 20) begin
            @(posedge clock); #1;
            lat++;
            req_valid[i] = 1'b0;
            if (resp_valid[i]) break;
        end
        check($sformatf("u%0d.resp_arrives", i), 64'(resp_valid[i]), 64'd1);
        rdata = resp_rdata[i];
        err   = resp_error[i];
        for (int h = 0; h < hold; h++) begin
            req_valid[i] = (h == 1);
            req_write[i] = 1'b1;
            req_addr[i]  = 64'h0;
            req_wdata[i] = 64'hBAD0_BAD0_BAD0_BAD0;
            @(posedge clock); #1;
        end
        req_valid[i] = 1'b0;
        if (hold > 0) begin
            check($sformatf("u%0d.held_rdata", i), resp_rdata[i], rdata);
            check($sformatf("u%0d.held_valid", i), 64'(resp_valid[i]), 64'd1);
        end
        resp_ready[i] = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        logic [63:0] rd;
        bit          er;
        int          lt;
        logic [63:0] vals [4];
        logic [63:0] got  [4];
        int          acc  [4];
        int          j, k;
        bit          rr;

        vals[0] = 64'h0123_4567_89AB_CDEF;
        vals[1] = 64'hFEDC_BA98_7654_3210;
        vals[2] = 64'h0000_0000_0000_00FF;
        vals[3] = 64'h8000_0000_0000_0001;

        reset = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        resp_ready = 2'b11;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        check("reset.req_ready",  64'(req_ready[0]),  64'd1);
        check("reset.busy",       64'(busy[0]),       64'd0);
        check("reset.resp_valid", 64'(resp_valid[0]), 64'd0);

        // First load of a cleared array.
        do_req(0, 1'b0, 64'h10, 64'h0, 0, rd, er, lt);
        check("ldur10.latency", 64'(lt), 64'd2);
        check("ldur10.rdata",   rd,      64'd0);
        check("ldur10.error",   64'(er), 64'd0);

        // Store then load back.
        do_req(0, 1'b1, 64'h18, 64'hDEAD_BEEF_CAFE_F00D, 0, rd, er, lt);
        check("stur18.rdata", rd,      64'd0);
        check("stur18.error", 64'(er), 64'd0);
        do_req(0, 1'b0, 64'h18, 64'h0, 0, rd, er, lt);
        check("ldur18.rdata", rd, 64'hDEAD_BEEF_CAFE_F00D);

        // Misaligned and out-of-range accesses.
        do_req(0, 1'b0, 64'h1C, 64'h0, 0, rd, er, lt);
        check("ldur1c.error", 64'(er), 64'd1);
        check("ldur1c.rdata", rd,      64'd0);
        do_req(0, 1'b0, 64'h800, 64'h0, 0, rd, er, lt);
        check("ldur800.error", 64'(er), 64'd1);
        check("ldur800.rdata", rd,      64'd0);
        do_req(0, 1'b1, 64'h800, 64'h1234_5678, 0, rd, er, lt);
        check("stur800.error", 64'(er), 64'd1);
        do_req(0, 1'b0, 64'h0, 64'h0, 0, rd, er, lt);
        check("ldur0.after_oob_store", rd, 64'd0);

        // Back-pressure: response held 5 cycles, stray store dropped.
        do_req(0, 1'b0, 64'h18, 64'h0, 5, rd, er, lt);
        check("hold.rdata", rd, 64'hDEAD_BEEF_CAFE_F00D);
        do_req(0, 1'b0, 64'h0, 64'h0, 0, rd, er, lt);
        check("hold.stray_dropped", rd, 64'd0);

        // Reset while a store waits; reset lands on its commit edge.
        req_valid[0] = 1'b1; req_write[0] = 1'b1;
        req_addr[0]  = 64'h20; req_wdata[0] = 64'h55;
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        check("midreset.busy_before", 64'(busy[0]), 64'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("midreset.busy",       64'(busy[0]),       64'd0);
        check("midreset.req_ready",  64'(req_ready[0]),  64'd1);
        check("midreset.resp_valid", 64'(resp_valid[0]), 64'd0);
        reset = 1'b0;
        do_req(0, 1'b0, 64'h20, 64'h0, 0, rd, er, lt);
        check("midreset.ldur20", rd, 64'd0);

        // LATENCY=1: fill four words, then stream four loads.
        for (int a = 0; a < 4; a++) begin
            do_req(1, 1'b1, 64'(a * 8), vals[a], 0, rd, er, lt);
            if (a == 0) check("lat1.latency", 64'(lt), 64'd1);
        end
        j = 0; k = 0;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 64'h0;
        rr = req_ready[1];
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(posedge clock); #1;
            if (rr && req_valid[1]) begin
                acc[j] = cyc;
                j++;
                if (j < 4) req_addr[1] = 64'(j * 8);
                else       req_valid[1] = 1'b0;
            end
            if (resp_valid[1] && k < 4) begin
                got[k] = resp_rdata[1];
                k++;
            end
            rr = req_ready[1];
        end
        req_valid[1] = 1'b0;
        check("b2b.responses", 64'(k), 64'd4);
        if (k == 4) begin
            for (int a = 0; a < 4; a++) begin
                check($sformatf("b2b.data%0d", a), got[a], vals[a]);
                if (a > 0) check($sformatf("b2b.spacing%0d", a), 64'(acc[a] - acc[a-1]), 64'd2);
            end
        end

        repeat (3) @(posedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
